// File: rtl/req_gnt_ctrl_pkg.sv
// req_gnt_pkg: shared channel-id and pipeline-entry types plus reset values
// for req_gnt_ctrl and its round-robin arbiter.
package req_gnt_pkg;

  // Ids are sized for the largest supported channel count; unused upper bits trim away.
  localparam int N_CH_MAX = 16;
  localparam int CH_ID_W  = $clog2(N_CH_MAX);

  typedef logic [CH_ID_W-1:0] ch_id_t;

  typedef struct packed {
    logic   valid;
    ch_id_t id;
  } pipe_entry_t;

  localparam pipe_entry_t PIPE_ENTRY_RST = '{valid: 1'b0, id: '0};
  localparam ch_id_t      PTR_RST        = '0;

endpackage

// File: rtl/req_gnt_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first eligible channel
// at or after i_ptr; the pointer itself is owned by the caller.
module rr_arbiter
  import req_gnt_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0] i_eligible,
  input  ch_id_t          i_ptr,
  output logic            o_valid,
  output ch_id_t          o_winner
);

  logic [N_CH-1:0] w_rotated;
  int              w_sum;

  // Rotate so bit 0 is the channel at the pointer, then take the lowest set bit.
  assign w_rotated = N_CH'({i_eligible, i_eligible} >> i_ptr);

  always_comb begin
    o_valid  = 1'b0;
    o_winner = '0;
    w_sum    = 0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (w_rotated[k]) begin
        w_sum = int'(i_ptr) + k;
        if (w_sum >= N_CH) begin
          w_sum = w_sum - N_CH;
        end
        o_valid  = 1'b1;
        o_winner = ch_id_t'(w_sum);
      end
    end
  end

endmodule

// File: rtl/req_gnt_ctrl.sv
// req_gnt_ctrl: round-robin request/grant controller with a fixed LATENCY grant pipeline.
// Define REQ_GNT_TIMEOUT_EN to add the TIMEOUT parameter, per-channel watchdogs and o_to_err.
module req_gnt_ctrl
  import req_gnt_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int LATENCY = 3
`ifdef REQ_GNT_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 15
`endif
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_req,
  output logic [N_CH-1:0] o_gnt,
  output logic [N_CH-1:0] o_busy
`ifdef REQ_GNT_TIMEOUT_EN
  ,
  output logic [N_CH-1:0] o_to_err
`endif
);

  logic [N_CH-1:0] w_eligible;
  logic [N_CH-1:0] w_accept;
  logic [N_CH-1:0] w_gnt;
  logic            w_grantValid;
  ch_id_t          w_winner;

  ch_id_t          r_ptr;
  logic [N_CH-1:0] r_busy;
  pipe_entry_t     r_pipe [LATENCY];

  assign w_eligible = i_req & ~r_busy;

  rr_arbiter #(
    .N_CH(N_CH)
  ) u_arbiter (
    .i_eligible(w_eligible),
    .i_ptr     (r_ptr),
    .o_valid   (w_grantValid),
    .o_winner  (w_winner)
  );

  always_comb begin
    w_accept = '0;
    w_gnt    = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_accept[i] = w_grantValid && (w_winner == ch_id_t'(i));
      w_gnt[i]    = r_pipe[LATENCY-1].valid && (r_pipe[LATENCY-1].id == ch_id_t'(i));
    end
  end

  // A channel's busy clears on the edge its grant is sampled, so it can re-arbitrate one edge later.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr  <= PTR_RST;
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_gnt) | w_accept;
      if (w_grantValid) begin
        r_ptr <= (w_winner == ch_id_t'(N_CH - 1)) ? PTR_RST : w_winner + ch_id_t'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < LATENCY; s++) begin
        r_pipe[s] <= PIPE_ENTRY_RST;
      end
    end else begin
      r_pipe[0] <= '{valid: w_grantValid, id: w_winner};
      for (int s = 1; s < LATENCY; s++) begin
        r_pipe[s] <= r_pipe[s-1];
      end
    end
  end

  assign o_gnt  = w_gnt;
  assign o_busy = r_busy;

`ifdef REQ_GNT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_toCnt [N_CH];
  logic [N_CH-1:0]  r_toErr;

  // Flag is raised on the same edge the saturating wait counter reaches TIMEOUT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_toErr <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_toCnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!i_req[i] || w_gnt[i]) begin
          r_toCnt[i] <= '0;
        end else if (r_toCnt[i] != CNT_W'(TIMEOUT)) begin
          r_toCnt[i] <= r_toCnt[i] + CNT_W'(1);
        end
        if (i_req[i] && !w_gnt[i] && (r_toCnt[i] >= CNT_W'(TIMEOUT - 1))) begin
          r_toErr[i] <= 1'b1;
        end
      end
    end
  end

  assign o_to_err = r_toErr;
`endif

endmodule

// File: tb/tb_req_gnt_ctrl.sv
// tb_req_gnt_ctrl: vector table, hand-written corner sequences and a randomized
// run compared against a due-edge reference model of the request/grant rules.
`timescale 1ns/1ps
module tb_req_gnt_ctrl;

  localparam int N_CH = 4;
  localparam int LAT  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            rst1;
  logic [N_CH-1:0] req;
  logic [N_CH-1:0] req1;
  logic [N_CH-1:0] gnt;
  logic [N_CH-1:0] busy;
  logic [N_CH-1:0] gnt1;
  logic [N_CH-1:0] busy1;
`ifdef REQ_GNT_TIMEOUT_EN
  logic [N_CH-1:0] toErr;
  logic [N_CH-1:0] toErr1;
`endif

  int errCount   = 0;
  int checkCount = 0;

  typedef struct {
    logic            rst;
    logic [N_CH-1:0] req;
    logic [N_CH-1:0] expGnt;
    logic [N_CH-1:0] expBusy;
  } vec_t;

  vec_t vecs[$];

  // Model: each channel holds the edge number at which its grant is sampled, or -1 when idle.
  int mDue[N_CH];
  int mPtr  = 0;
  int mEdge = 0;

  always #5 clk = ~clk;

  req_gnt_ctrl #(
    .N_CH   (N_CH),
    .LATENCY(LAT)
`ifdef REQ_GNT_TIMEOUT_EN
    ,
    .TIMEOUT(5)
`endif
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_req (req),
    .o_gnt (gnt),
    .o_busy(busy)
`ifdef REQ_GNT_TIMEOUT_EN
    ,
    .o_to_err(toErr)
`endif
  );

  req_gnt_ctrl #(
    .N_CH   (N_CH),
    .LATENCY(1)
`ifdef REQ_GNT_TIMEOUT_EN
    ,
    .TIMEOUT(5)
`endif
  ) dut1 (
    .i_clk (clk),
    .i_rst (rst1),
    .i_req (req1),
    .o_gnt (gnt1),
    .o_busy(busy1)
`ifdef REQ_GNT_TIMEOUT_EN
    ,
    .o_to_err(toErr1)
`endif
  );

  function automatic void addVec(input logic r, input logic [N_CH-1:0] q,
                                 input logic [N_CH-1:0] g, input logic [N_CH-1:0] b);
    vecs.push_back('{r, q, g, b});
  endfunction

  task automatic modelStep(input logic rstIn, input logic [N_CH-1:0] reqIn);
    int w;
    int c;
    if (rstIn) begin
      for (int i = 0; i < N_CH; i++) mDue[i] = -1;
      mPtr = 0;
    end else begin
      w = -1;
      for (int k = 0; k < N_CH; k++) begin
        c = (mPtr + k) % N_CH;
        if (w < 0 && reqIn[c] && mDue[c] < 0) w = c;
      end
      for (int i = 0; i < N_CH; i++) begin
        if (mDue[i] == mEdge) mDue[i] = -1;
      end
      if (w >= 0) begin
        mDue[w] = mEdge + LAT;
        mPtr    = (w + 1) % N_CH;
      end
    end
    mEdge++;
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    modelStep(rst, req);
    @(negedge clk);
  endtask

  task automatic checkValue(input string name, input logic [N_CH-1:0] got,
                            input logic [N_CH-1:0] want);
    checkCount++;
    if (got !== want) begin
      errCount++;
      $display("[TB] FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic checkOutput(input string name, input logic [N_CH-1:0] expGnt,
                             input logic [N_CH-1:0] expBusy);
    checkValue({name, "_gnt"}, gnt, expGnt);
    checkValue({name, "_busy"}, busy, expBusy);
    checkCount++;
    if ($countones(gnt) > 1) begin
      errCount++;
      $display("[TB] FAIL %s_onehot: got %b want at most one bit", name, gnt);
    end
  endtask

  function automatic logic [N_CH-1:0] modelGnt();
    logic [N_CH-1:0] g;
    for (int i = 0; i < N_CH; i++) g[i] = (mDue[i] == mEdge);
    return g;
  endfunction

  function automatic logic [N_CH-1:0] modelBusy();
    logic [N_CH-1:0] b;
    for (int i = 0; i < N_CH; i++) b[i] = (mDue[i] >= 0);
    return b;
  endfunction

  initial begin
    for (int i = 0; i < N_CH; i++) mDue[i] = -1;
    rst  = 1'b1;
    req  = '0;
    rst1 = 1'b1;
    req1 = '0;
    applyStimulus();
    applyStimulus();
    checkOutput("reset", 4'b0000, 4'b0000);

    // req[0] held: grants sampled at edges 3 and 7.
    addVec(1'b1, 4'b0000, 4'b0000, 4'b0000);
    addVec(1'b0, 4'b0001, 4'b0000, 4'b0001);
    addVec(1'b0, 4'b0001, 4'b0000, 4'b0001);
    addVec(1'b0, 4'b0001, 4'b0001, 4'b0001);
    addVec(1'b0, 4'b0001, 4'b0000, 4'b0000);
    addVec(1'b0, 4'b0001, 4'b0000, 4'b0001);
    addVec(1'b0, 4'b0001, 4'b0000, 4'b0001);
    addVec(1'b0, 4'b0001, 4'b0001, 4'b0001);
    addVec(1'b0, 4'b0001, 4'b0000, 4'b0000);
    // All four held: accepted in order, ch0 re-accepted at edge 4.
    addVec(1'b1, 4'b0000, 4'b0000, 4'b0000);
    addVec(1'b0, 4'b1111, 4'b0000, 4'b0001);
    addVec(1'b0, 4'b1111, 4'b0000, 4'b0011);
    addVec(1'b0, 4'b1111, 4'b0001, 4'b0111);
    addVec(1'b0, 4'b1111, 4'b0010, 4'b1110);
    addVec(1'b0, 4'b1111, 4'b0100, 4'b1101);
    addVec(1'b0, 4'b1111, 4'b1000, 4'b1011);
    addVec(1'b0, 4'b1111, 4'b0001, 4'b0111);
    // Reset with ch1 in flight: no grant afterwards, pointer back at ch0.
    addVec(1'b1, 4'b0000, 4'b0000, 4'b0000);
    addVec(1'b0, 4'b0010, 4'b0000, 4'b0010);
    addVec(1'b0, 4'b0000, 4'b0000, 4'b0010);
    addVec(1'b1, 4'b0000, 4'b0000, 4'b0000);
    for (int e = 3; e <= 10; e++) addVec(1'b0, 4'b0000, 4'b0000, 4'b0000);
    addVec(1'b0, 4'b1111, 4'b0000, 4'b0001);
    // One-edge pulse on req[2] still earns its grant.
    addVec(1'b1, 4'b0000, 4'b0000, 4'b0000);
    addVec(1'b0, 4'b0100, 4'b0000, 4'b0100);
    addVec(1'b0, 4'b0000, 4'b0000, 4'b0100);
    addVec(1'b0, 4'b0000, 4'b0100, 4'b0100);
    addVec(1'b0, 4'b0000, 4'b0000, 4'b0000);

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      req = vecs[i].req;
      applyStimulus();
      checkOutput($sformatf("vec%0d", i), vecs[i].expGnt, vecs[i].expBusy);
    end

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      req = N_CH'($urandom);
      applyStimulus();
      checkOutput($sformatf("rand%0d", n), modelGnt(), modelBusy());
    end

    // LATENCY=1 instance: held req[3] grants on every second edge.
    rst  = 1'b1;
    req  = '0;
    rst1 = 1'b0;
    req1 = 4'b1000;
    for (int e = 0; e < 8; e++) begin
      applyStimulus();
      checkValue($sformatf("lat1_gnt%0d", e), gnt1, (e % 2 == 0) ? 4'b1000 : 4'b0000);
      checkValue($sformatf("lat1_busy%0d", e), busy1, (e % 2 == 0) ? 4'b1000 : 4'b0000);
    end
    for (int n = 0; n < 100; n++) begin
      req1 = N_CH'($urandom);
      applyStimulus();
      checkCount++;
      if ($countones(gnt1) > 1 || (gnt1 & ~busy1) != '0) begin
        errCount++;
        $display("[TB] FAIL lat1_rand%0d: gnt %b busy %b want one-hot gnt within busy",
                 n, gnt1, busy1);
      end
    end

`ifdef REQ_GNT_TIMEOUT_EN
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    req = 4'b1111;
    for (int e = 0; e < 12; e++) applyStimulus();
    checkValue("to_err_set", toErr, 4'b1100);
    req = 4'b0000;
    for (int e = 0; e < 6; e++) applyStimulus();
    checkValue("to_err_sticky", toErr, 4'b1100);
    rst = 1'b1;
    applyStimulus();
    checkValue("to_err_reset", toErr, 4'b0000);
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/req_gnt_ctrl.md
# req_gnt_ctrl

Parametrised multi-channel request/grant controller. It is the successor to the fixed three-flop single-channel request/grant delay. It accepts level requests from N_CH requesters through a round-robin arbiter, at most one per cycle. Each accepted request travels through a LATENCY-stage pipeline and returns a one-cycle grant pulse on its own channel. It sits between bus masters and a fixed-latency shared resource, and is the DUT for the team's request/grant SVA benches.

## Interface
- N_CH, 4, number of requester channels (≥2)
- LATENCY, 3, edges from acceptance to the edge at which gnt is sampled high (≥1)
- TIMEOUT, 15, watchdog threshold in edges (used only with the macro)
- clk  input  1  single clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- req  input  N_CH  per-channel level request; held high until its gnt is sampled
- gnt  output  N_CH  per-channel grant pulse, one cycle wide, registered
- busy  output  N_CH  channel accepted and grant not yet delivered
- to_err  output  N_CH  sticky watchdog flag (present only with the macro)

## Operation
- Eligibility: a channel is eligible at an edge if req[i]=1 and busy[i]=0.
- Arbitration: round-robin over eligible channels, starting at pointer ptr.
  - At most one acceptance per edge.
  - On acceptance of channel w, ptr <= (w+1) mod N_CH.
  - With no acceptance, ptr holds.
- Acceptance at edge k:
  - busy[w] <= 1.
  - {valid=1, id=w} enters pipeline stage 1.
- Pipeline: LATENCY-1 further register stages carry {valid, id}.
  - gnt is decoded from the last stage: gnt[id]=valid.
  - At most one gnt bit is high in any cycle.
- Completion: at the edge where gnt[i] is sampled high, busy[i] <= 0.
  - The channel is eligible again from the following edge.
  - If req[i] is still high then, it counts as a new request.
- Dropping req while busy does not cancel the request; its gnt is still delivered.
- Reset:
  - gnt=0, busy=0, ptr=0 (channel 0 has priority), all pipeline valids cleared, to_err=0.
  - Reset mid-operation discards in-flight requests. No gnt from them appears after reset.

## Timing
- Request accepted at edge k gives gnt high in the cycle after edge k+LATENCY-1, so it is sampled high at edge k+LATENCY. This preserves the "req ##LATENCY gnt" property of the predecessor.
- A single channel holding req continuously is accepted every LATENCY+1 edges.
- Aggregate throughput is one acceptance per edge. The pipeline never stalls, and there is no backpressure.
- Worst-case acceptance wait for an eligible channel is N_CH-1 edges, because round-robin gives no starvation.
- Simultaneous gnt for channel i and a new req on channel j≠i: independent; both proceed in the same edge.

## Configuration
- REQ_GNT_TIMEOUT_EN defined:
  - Each channel has a counter of width $clog2(TIMEOUT+1), saturating.
  - The counter increments at each edge with req[i]=1 and gnt[i]=0.
  - It clears at any edge with req[i]=0 or gnt[i]=1.
  - When the counter reaches TIMEOUT, to_err[i] <= 1, sticky until rst.
- REQ_GNT_TIMEOUT_EN undefined: no counters and no to_err port. Everything else is cycle-identical.

## Structure
- Package req_gnt_pkg:
  - ch_id_t typedef (width $clog2(N_CH) from a package localparam default).
  - pipe_entry_t struct {valid, id}.
  - Reset-value constants.
- Sub-module rr_arbiter:
  - Inputs: eligible vector and ptr.
  - Outputs: grant-valid and winner index.
  - Purely combinational; ptr update stays in req_gnt_ctrl.
- Top level holds busy, ptr, the pipeline array, gnt decode, and the optional watchdog.

## Test plan
- N_CH=4, LATENCY=3, req[0] raised before edge 0 and held:
  - gnt[0] sampled high at edge 3 only, and again at edge 7.
  - busy[0] high at edges 1–3.
- req=4'b1111 from edge 0, held:
  - Accepts ch0..3 at edges 0..3.
  - gnt sampled at edges 3,4,5,6 in order.
  - ch0 re-accepted at edge 4, with gnt at edge 7.
- req[1] accepted at edge 0, rst high at edge 2:
  - No gnt through edge 10.
  - busy=0 after edge 2.
  - ptr back to 0.
- req[2] pulsed high for one edge only (accepted edge 0): gnt[2] still sampled high at edge 3.
- LATENCY=1: req[3] held gives a gnt[3] pulse every second edge, and no two gnt bits are ever high together.
- REQ_GNT_TIMEOUT_EN, TIMEOUT=5, req=4'b1111 at edge 0:
  - to_err[2] and to_err[3] set, to_err[0] and to_err[1] stay 0.
  - The flags stay set until rst.
